// File: rtl/sd_sector_reader_pkg.sv
// Shared constants and types for the SPI-mode SD single-block (CMD17) reader.
// Byte values and error codes mirror the CPU-side firmware headers.
package sd_sector_reader_pkg;

  localparam logic [7:0] CMD17 = 8'h51;
  localparam logic [7:0] TOKEN = 8'hFE;
  localparam logic [7:0] FILL  = 8'hFF;

  localparam logic [1:0] ERR_OK         = 2'd0;
  localparam logic [1:0] ERR_R1_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_R1_NONZERO = 2'd2;
  localparam logic [1:0] ERR_TOKEN      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC, ST_FIN
  } state_t;

  typedef enum logic [1:0] {X_IDLE, X_XFER, X_GAP} xfer_state_t;

  typedef struct packed {
    state_t      main;
    xfer_state_t xfer;
  } dbg_t;

  // SDHC cards take a sector index, SDSC cards take a byte address.
  function automatic logic [31:0] cmd_arg(input logic [31:0] sector, input bit block_addr);
    return block_addr ? sector : {sector[22:0], 9'b0};
  endfunction

endpackage

// File: rtl/sd_sector_reader_if.sv
// Byte port of the SPI byte/word register engine as seen by the sector reader.
interface sd_sector_reader_if;
  // Handshake: spi_byte_we is the request and is held with spi_di stable until the
  // cycle spi_byte_we && !spi_wait, in which spi_do[7:0] is valid and the byte is
  // taken; spi_byte_we then drops for at least one cycle before the next request.
  logic        spi_byte_we;
  logic [31:0] spi_di;
  logic [31:0] spi_do;
  logic        spi_wait;

  modport master (output spi_byte_we, output spi_di, input spi_do, input spi_wait);
  modport slave  (input spi_byte_we, input spi_di, output spi_do, output spi_wait);
endinterface

// File: rtl/sd_sector_reader_byte_xfer.sv
// One SPI byte exchange: request, completion capture, then a single low cycle
// so the engine sees a fresh rising edge on the next request.
module sd_sector_reader_byte_xfer
  import sd_sector_reader_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      go,
  input  logic [7:0]                tx,
  output logic                      rdy,
  output logic [7:0]                rx,
  output xfer_state_t               state,
  sd_sector_reader_if.master        spi
);

  xfer_state_t state_d;
  logic [7:0]  tx_q;
  logic        rx_unused;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= X_IDLE;
      tx_q  <= '0;
    end else begin
      state <= state_d;
      if (go) tx_q <= tx;
    end
  end

  // A new request is accepted straight out of GAP, keeping the low time at one cycle.
  always_comb begin
    state_d = state;
    case (state)
      X_IDLE:  if (go) state_d = X_XFER;
      X_XFER:  if (!spi.spi_wait) state_d = X_GAP;
      X_GAP:   state_d = go ? X_XFER : X_IDLE;
      default: state_d = X_IDLE;
    endcase
  end

  assign spi.spi_byte_we = (state == X_XFER);
  assign spi.spi_di      = {24'd0, tx_q};
  assign rdy             = (state == X_XFER) && !spi.spi_wait;
  assign rx              = spi.spi_do[7:0];
  assign rx_unused       = ^spi.spi_do[31:8];

endmodule

// File: rtl/sd_sector_reader.sv
// CMD17 single-block read sequencer: issues the command, polls R1 and the data
// token, streams 512 data bytes to the consumer and drops the CRC.
module sd_sector_reader
  import sd_sector_reader_pkg::*;
#(
  parameter bit BLOCK_ADDR = 1'b1,
  parameter int R1_POLLS   = 16,
  parameter int TOKEN_MAX  = 65535
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [31:0]        sector,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [7:0]         r1,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  sd_sector_reader_if.master spi,
  output dbg_t               dbg
);

  state_t      state_q, state_d;
  xfer_state_t xfer_state;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] arg_q;
  logic        pending_q;
  logic        go, rdy, fin;
  logic [7:0]  tx, rx;
  logic        err_d, valid_d;
  logic [1:0]  code_d;
  logic [7:0]  r1_d, data_d;

  sd_sector_reader_byte_xfer u_xfer (
    .clk(clk), .resetn(resetn), .go(go), .tx(tx),
    .rdy(rdy), .rx(rx), .state(xfer_state), .spi(spi)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      arg_q     <= '0;
      pending_q <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_OK;
      r1        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done      <= fin;
      err       <= err_d;
      err_code  <= code_d;
      r1        <= r1_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      if (go) pending_q <= 1'b1;
      else if (rdy) pending_q <= 1'b0;
      if (state_q == ST_IDLE && start) arg_q <= cmd_arg(sector, BLOCK_ADDR);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err;
    code_d  = err_code;
    r1_d    = r1;
    data_d  = out_data;
    valid_d = out_valid;
    fin     = 1'b0;
    tx      = FILL;
    go      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_PRE;
        cnt_d   = '0;
        err_d   = 1'b0;
        code_d  = ERR_OK;
      end
      ST_PRE: if (rdy) state_d = ST_CMD;
      ST_CMD: begin
        case (cnt_q[2:0])
          3'd0:    tx = CMD17;
          3'd1:    tx = arg_q[31:24];
          3'd2:    tx = arg_q[23:16];
          3'd3:    tx = arg_q[15:8];
          3'd4:    tx = arg_q[7:0];
          default: tx = FILL;
        endcase
        if (rdy) begin
          if (cnt_q == 16'd5) begin
            state_d = ST_R1;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 16'd1;
        end
      end
      ST_R1: if (rdy) begin
        if (rx != FILL) begin
          r1_d  = rx;
          cnt_d = '0;
          if (rx == 8'h00) state_d = ST_TOKEN;
          else begin
            state_d = ST_FIN;
            err_d   = 1'b1;
            code_d  = ERR_R1_NONZERO;
          end
        end else if (cnt_q == 16'(R1_POLLS - 1)) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
          code_d  = ERR_R1_TIMEOUT;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_TOKEN: if (rdy) begin
        if (rx == TOKEN) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else if (rx != FILL || cnt_q == 16'(TOKEN_MAX - 1)) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
          code_d  = ERR_TOKEN;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_DATA: begin
        if (rdy) begin
          data_d  = rx;
          valid_d = 1'b1;
        end
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          cnt_d   = {7'd0, cnt_q[8:0] + 9'd1};
          if (cnt_q[8:0] == 9'h1FF) state_d = ST_CRC;
        end
      end
      ST_CRC: if (rdy) begin
        if (cnt_q == 16'd1) state_d = ST_FIN;
        else cnt_d = cnt_q + 16'd1;
      end
      ST_FIN: if (rdy) begin
        state_d = ST_IDLE;
        fin     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // In DATA the next byte may issue in the same cycle the held byte is accepted;
    // the last accepted byte's request is then the first CRC byte (also a filler).
    if (state_q != ST_IDLE && !pending_q)
      go = (state_q == ST_DATA) ? (!out_valid || out_ready) : 1'b1;
  end

  assign busy     = (state_q != ST_IDLE);
  assign dbg.main = state_q;
  assign dbg.xfer = xfer_state;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: behavioural SPI byte engine plus scripted SD card,
// a vector table of read scenarios, and hand sequences for reset and SDSC addressing.
module tb_sd_sector_reader;
  import sd_sector_reader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start, out_ready, busy, done, err, out_valid;
  logic [31:0] sector;
  logic [1:0]  err_code;
  logic [7:0]  r1, out_data;
  dbg_t        dbg;
  logic        start_b, out_ready_b, busy_b, done_b, err_b, out_valid_b;
  logic [31:0] sector_b;
  logic [1:0]  err_code_b;
  logic [7:0]  r1_b, out_data_b;
  dbg_t        dbg_b;

  sd_sector_reader_if sif ();
  sd_sector_reader_if sif_b ();

  sd_sector_reader #(.BLOCK_ADDR(1'b1), .R1_POLLS(16), .TOKEN_MAX(65535)) dut (
    .clk(clk), .resetn(resetn), .start(start), .sector(sector), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .r1(r1), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .spi(sif), .dbg(dbg)
  );

  sd_sector_reader #(.BLOCK_ADDR(1'b0), .R1_POLLS(16), .TOKEN_MAX(65535)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .sector(sector_b), .busy(busy_b),
    .done(done_b), .err(err_b), .err_code(err_code_b), .r1(r1_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .spi(sif_b), .dbg(dbg_b)
  );

  typedef struct {
    logic [31:0] sector;
    int          r1_fill;
    logic [7:0]  r1_val;
    int          tok_fill;
    logic [7:0]  tok_val;
    int          mode;
    bit          poke;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_r1;
    int          exp_xfers;
    int          exp_data;
  } vec_t;

  vec_t       vecs[6];
  int         checks = 0, failures = 0;
  int         xfers = 0, op_base = 0, di_hi_bad = 0, stall_bad = 0, outside_bad = 0;
  int         r1_fill = 0, tok_fill = 0, mode = 0;
  logic [7:0] r1_val = 8'h00, tok_val = 8'hFE;
  logic [7:0] mosi_log[$];
  logic [7:0] mosi_b[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Card script by transfer index: 7 command bytes, R1 after r1_fill fillers,
  // token after tok_fill fillers, 512 bytes i&0xFF, then idle fillers.
  function automatic logic [7:0] miso_for(input int k);
    int j;
    j = k - 7;
    if (j < 0 || j < r1_fill) return 8'hFF;
    if (j == r1_fill) return r1_val;
    j = j - r1_fill - 1;
    if (j < tok_fill) return 8'hFF;
    if (j == tok_fill) return tok_val;
    j = j - tok_fill - 1;
    if (j < 512) return j[7:0];
    return 8'hFF;
  endfunction

  // SPI engine for the SDHC instance, with 0..2 cycles of random transfer latency.
  initial begin
    int lat;
    lat = 0;
    sif.spi_wait = 1'b1;
    sif.spi_do   = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (sif.spi_byte_we && sif.spi_wait) begin
        if (lat == 0) begin
          mosi_log.push_back(sif.spi_di[7:0]);
          if (sif.spi_di[31:8] != 24'd0) di_hi_bad++;
          sif.spi_do   = {24'hA5C3_96, miso_for(xfers - op_base)};
          sif.spi_wait = 1'b0;
          xfers++;
        end else lat--;
      end else if (!sif.spi_byte_we) begin
        sif.spi_wait = 1'b1;
        lat = $urandom_range(0, 2);
      end
    end
  end

  // SPI engine for the SDSC instance: card never answers.
  initial begin
    sif_b.spi_wait = 1'b1;
    sif_b.spi_do   = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (sif_b.spi_byte_we && sif_b.spi_wait) begin
        mosi_b.push_back(sif_b.spi_di[7:0]);
        sif_b.spi_wait = 1'b0;
      end else if (!sif_b.spi_byte_we) sif_b.spi_wait = 1'b1;
    end
  end

  // Consumer: ready pattern per mode, records accepted bytes and protocol breaches.
  initial begin
    int  cyc;
    logic prev_we, prev_stall;
    cyc = 0; prev_we = 1'b0; prev_stall = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (out_valid && dbg.main != ST_DATA) outside_bad++;
      if (sif.spi_byte_we && !prev_we && prev_stall) stall_bad++;
      prev_we    = sif.spi_byte_we;
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic run_op(input vec_t v, input string tag);
    int n, dones, base_g, base_s, base_o, base_h, nonfill, mism;
    logic [55:0] hdr;
    r1_fill = v.r1_fill; r1_val = v.r1_val; tok_fill = v.tok_fill; tok_val = v.tok_val;
    mode = v.mode;
    base_g = got_q.size(); base_s = stall_bad; base_o = outside_bad; base_h = di_hi_bad;
    @(negedge clk);
    op_base = xfers;
    sector = v.sector; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; dones = 0;
    while (dones == 0 && n < 20000) begin
      if (v.poke && n == 40) begin sector = ~v.sector; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      n++;
      if (done) dones++;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(dones), 64'd1);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " err"}, 64'(err), 64'(v.exp_err));
    chk({tag, " err_code"}, 64'(err_code), 64'(v.exp_code));
    chk({tag, " r1"}, 64'(r1), 64'(v.exp_r1));
    dones = 0;
    repeat (3) begin @(negedge clk); if (done) dones++; end
    chk({tag, " done_single"}, 64'(dones), 64'd0);
    chk({tag, " err_sticky"}, 64'(err), 64'(v.exp_err));
    chk({tag, " xfers"}, 64'(xfers - op_base), 64'(v.exp_xfers));
    hdr = '0; nonfill = 0;
    for (int j = 0; j < 7; j++)
      if (op_base + j < mosi_log.size()) hdr = {hdr[47:0], mosi_log[op_base + j]};
    for (int j = op_base + 7; j < mosi_log.size(); j++)
      if (mosi_log[j] != 8'hFF) nonfill++;
    chk({tag, " mosi_header"}, 64'(hdr), 64'({8'hFF, CMD17, v.sector, 8'hFF}));
    chk({tag, " mosi_fillers"}, 64'(nonfill), 64'd0);
    exp_q.delete();
    for (int i = 0; i < v.exp_data; i++) exp_q.push_back(8'(i));
    chk({tag, " data_count"}, 64'(got_q.size() - base_g), 64'(v.exp_data));
    mism = 0;
    for (int i = 0; base_g + i < got_q.size() && exp_q.size() > 0; i++)
      if (got_q[base_g + i] != exp_q.pop_front()) mism++;
    chk({tag, " data_bytes"}, 64'(mism), 64'd0);
    chk({tag, " we_during_stall"}, 64'(stall_bad - base_s), 64'd0);
    chk({tag, " valid_outside_data"}, 64'(outside_bad - base_o), 64'd0);
    chk({tag, " di_upper_zero"}, 64'(di_hi_bad - base_h), 64'd0);
  endtask

  initial begin
    int n, dones, base_g;
    resetn = 1'b0; start = 1'b0; sector = '0;
    start_b = 1'b0; sector_b = '0; out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset outputs", 64'({done, err, err_code, r1, out_valid}), 64'd0);
    chk("reset spi", 64'({sif.spi_byte_we, sif.spi_di}), 64'd0);
    chk("reset state", 64'(dbg.main), 64'(ST_IDLE));
    resetn = 1'b1;

    vecs[0] = '{32'h0000_1234, 2, 8'h00, 0, 8'hFE, 0, 1'b0, 1'b0, ERR_OK, 8'h00, 526, 512};
    vecs[1] = '{32'hDEAD_BEEF, 0, 8'h00, 5, 8'hFE, 1, 1'b1, 1'b0, ERR_OK, 8'h00, 529, 512};
    vecs[2] = '{32'h0000_0042, 1, 8'h04, 0, 8'hFE, 0, 1'b0, 1'b1, ERR_R1_NONZERO, 8'h04, 10, 0};
    vecs[3] = '{32'h0000_0007, 1000, 8'h00, 0, 8'hFE, 0, 1'b0, 1'b1, ERR_R1_TIMEOUT, 8'h04, 24, 0};
    vecs[4] = '{32'h1000_0000, 0, 8'h00, 3, 8'h05, 0, 1'b0, 1'b1, ERR_TOKEN, 8'h00, 13, 0};
    vecs[5] = '{32'hFFFF_FFFE, 15, 8'h00, 0, 8'hFE, 2, 1'b0, 1'b0, ERR_OK, 8'h00, 539, 512};
    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of the data phase, then a clean read.
    r1_fill = 2; r1_val = 8'h00; tok_fill = 0; tok_val = 8'hFE; mode = 0;
    base_g = got_q.size();
    @(negedge clk);
    op_base = xfers; sector = 32'h0000_0055; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got_q.size() - base_g < 100 && n < 20000) begin @(negedge clk); n++; end
    chk("midreset reached_byte100", 64'(got_q.size() - base_g >= 100), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midreset outputs", 64'({busy, done, err, err_code, r1, out_valid}), 64'd0);
    chk("midreset spi", 64'({sif.spi_byte_we, sif.spi_di}), 64'd0);
    dones = 0;
    repeat (3) begin @(negedge clk); if (done) dones++; end
    chk("midreset no_done", 64'(dones), 64'd0);
    resetn = 1'b1;
    run_op(vecs[0], "after_reset");

    // SDSC addressing: sector 3 becomes byte address 0x600.
    @(negedge clk);
    sector_b = 32'd3; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0; dones = 0;
    while (dones == 0 && n < 2000) begin @(negedge clk); n++; if (done_b) dones++; end
    chk("sdsc done_seen", 64'(dones), 64'd1);
    chk("sdsc err_code", 64'(err_code_b), 64'(ERR_R1_TIMEOUT));
    chk("sdsc mosi_count", 64'(mosi_b.size()), 64'd24);
    if (mosi_b.size() >= 6)
      chk("sdsc arg_bytes", 64'({mosi_b[0], mosi_b[1], mosi_b[2], mosi_b[3], mosi_b[4], mosi_b[5]}),
          64'h0000_FF51_0000_0600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
